change_payout_ctrl: RTL and testbench
=====================================

// Module: change_payout_ctrl
// PURPOSE
//  Sequences coin-change payout for the vending machine after a transaction finishes.
//  Takes a change amount in quarter-dollar units and selects coins greedily: $1, then $0.50, then $0.25.
//  Dispenses one coin at a time through a request/ack handshake with the coin hopper.
//  Keeps per-denomination stock counts and reports any shortfall to the top-level FSM.
// PARAMETERS
//  CNT_W       8    width of each coin stock counter
//  INIT_STOCK  10   stock loaded into every denomination at reset and on refill
//  TIMEOUT     15   WAIT cycles allowed with no ack before the payout aborts
// PORTS
//  in_clka         in   1      system clock, rising-edge
//  in_restart      in   1      synchronous reset, active-high
//  in_start        in   1      1-cycle pulse: begin payout; in_amount is sampled on the same edge
//  in_amount       in   16     signed change amount in quarter units ($1 = 4)
//  in_refill       in   1      sets all stocks to INIT_STOCK; acted on only in IDLE
//  in_hopper_ack   in   1      hopper has taken the coin currently requested
//  out_coin_1      out  1      request: dispense one $1 coin
//  out_coin_05     out  1      request: dispense one $0.50 coin
//  out_coin_025    out  1      request: dispense one $0.25 coin
//  out_busy        out  1      high in every state except IDLE
//  out_done        out  1      1-cycle pulse when the payout ends
//  out_short       out  1      1-cycle pulse with out_done when the full amount was not paid
//  out_remaining   out  16     signed amount still owed, in quarter units
//  out_paid_1      out  8      count of $1 coins dispensed in this payout, saturates at 255
//  out_stock_1     out  CNT_W  $1 coins in stock
//  out_stock_05    out  CNT_W  $0.50 coins in stock
//  out_stock_025   out  CNT_W  $0.25 coins in stock
// BEHAVIOUR
//  Reset values
//   - All outputs 0 except the three stocks, which reset to INIT_STOCK.
//   - State = IDLE; timeout counter = 0.
//   - Reset mid-payout drops every request on the same edge; no done pulse is issued.
//  State machine: IDLE, SELECT, WAIT, FINISH. All outputs are registered.
//  IDLE
//   - in_start with in_amount > 0: latch out_remaining = in_amount, clear out_paid_1, go to SELECT.
//   - in_start with in_amount == 0: go to FINISH, no short.
//   - in_start with in_amount < 0: latch the amount, go to FINISH with short set.
//   - in_refill without in_start: reload all stocks. If in_refill and in_start are both high, only the start is taken.
//  SELECT
//   - Pick the largest coin whose value <= out_remaining and whose stock > 0.
//   - Raise that request (exactly one-hot), clear the timeout counter, go to WAIT.
//   - If out_remaining == 0: go to FINISH, no short.
//   - If no coin qualifies: go to FINISH with short set.
//  WAIT
//   - Hold the request until in_hopper_ack is sampled high.
//   - On that edge: drop the request, subtract the coin value from out_remaining, decrement that stock, bump out_paid_1 if the coin was $1, go to SELECT.
//   - in_hopper_ack seen in any other state is ignored.
//   - If the counter reaches TIMEOUT with no ack: drop the request, go to FINISH with short set; the coin is not counted.
//  FINISH
//   - out_done = 1 for exactly one cycle, out_short as decided above, then go to IDLE.
//   - out_remaining and out_paid_1 keep their values until the next start.
//  Timing
//   - in_start sampled at edge N: first request is high after edge N+1.
//   - Ack sampled at edge M: the next request is high after edge M+1, i.e. one idle cycle between coins.
//  Ignored inputs and limits
//   - in_start while busy is ignored; in_amount is not re-sampled.
//   - in_refill while busy is ignored.
//   - A stock never decrements below 0 (the SELECT guard enforces this).
//   - out_paid_1 saturates at 255.
// TESTING
//  T1: stock 10/10/10, amount 7 -> coins 1, 05, 025 in that order; remaining 0; done, no short; stocks 9/9/9; paid_1 = 1.
//  T2: INIT_STOCK = 2, amount 12 -> coins 1, 1, 05, 05; stock_1 = 0 forces the fallback to 05; done, no short; stocks 0/0/2.
//  T3: INIT_STOCK = 1, amount 12 -> coins 1, 05, 025; remaining 5; done and short in the same cycle; stocks 0/0/0.
//  T4: amount 4, ack held low -> out_coin_1 stays high for TIMEOUT cycles, then done + short; remaining 4; stock_1 unchanged.
//  T5: amount -3 -> no coin request ever; done + short two cycles after start; remaining = -3.
//  T6: in_restart asserted in WAIT -> all requests 0 and busy 0 after the edge; stocks = INIT_STOCK; no done pulse.

Source files
------------

// File: rtl/change_payout_ctrl.sv
// change_payout_ctrl
// Sequences coin-change payout once a vending transaction finishes. The change
// amount (quarter units, $1 = 4) is paid greedily with $1, $0.50 and $0.25
// coins, one coin per request/ack handshake with the hopper. Per-denomination
// stock counters are kept here, and a shortfall is flagged together with done.
//
// Ports
//   in_clka        rising-edge clock
//   in_restart     synchronous active-high reset
//   in_start       1-cycle start pulse, in_amount sampled on the same edge
//   in_amount      signed change amount in quarter units
//   in_refill      reload every stock to INIT_STOCK (taken only in IDLE)
//   in_hopper_ack  hopper has taken the currently requested coin
//   out_coin_*     one-hot coin request ($1 / $0.50 / $0.25)
//   out_busy       high whenever the controller is not idle
//   out_done       1-cycle pulse at the end of a payout
//   out_short      pulses with out_done when the amount was not fully paid
//   out_remaining  signed amount still owed
//   out_paid_1     $1 coins paid in this payout, saturating at 255
//   out_stock_*    coins left per denomination
module change_payout_ctrl #(
    parameter int CNT_W      = 8,
    parameter int INIT_STOCK = 10,
    parameter int TIMEOUT    = 15
) (
    input  logic             in_clka,
    input  logic             in_restart,
    input  logic             in_start,
    input  logic [15:0]      in_amount,
    input  logic             in_refill,
    input  logic             in_hopper_ack,
    output logic             out_coin_1,
    output logic             out_coin_05,
    output logic             out_coin_025,
    output logic             out_busy,
    output logic             out_done,
    output logic             out_short,
    output logic [15:0]      out_remaining,
    output logic [7:0]       out_paid_1,
    output logic [CNT_W-1:0] out_stock_1,
    output logic [CNT_W-1:0] out_stock_05,
    output logic [CNT_W-1:0] out_stock_025
);

    localparam int                 TMO_W      = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(TIMEOUT - 1);
    localparam logic [TMO_W-1:0]   TMO_ZERO   = TMO_W'(0);
    localparam logic [TMO_W-1:0]   TMO_ONE    = TMO_W'(1);
    localparam logic [CNT_W-1:0]   STK_INIT   = CNT_W'(INIT_STOCK);
    localparam logic [CNT_W-1:0]   STK_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0]   STK_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SELECT = 2'd1,
        S_WAIT   = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t             state_q;
    logic [2:0]         req_q;          // {$1, $0.50, $0.25}
    logic               busy_q;
    logic               done_q;
    logic               short_q;
    logic               short_pend_q;   // shortfall decided before FINISH
    logic [15:0]        rem_q;
    logic [7:0]         paid_1_q;
    logic [CNT_W-1:0]   stock_1_q;
    logic [CNT_W-1:0]   stock_05_q;
    logic [CNT_W-1:0]   stock_025_q;
    logic [TMO_W-1:0]   tmo_q;
    logic [2:0]         coin_sel_d;

    // Value in quarter units of the coin encoded by a one-hot request.
    function automatic logic [15:0] coin_value(input logic [2:0] req);
        logic [15:0] v;
        case (req)
            3'b100:  v = 16'd4;
            3'b010:  v = 16'd2;
            3'b001:  v = 16'd1;
            default: v = 16'd0;
        endcase
        return v;
    endfunction

    // Increment that sticks at the all-ones value.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Greedy choice: largest coin that fits the remaining amount and is in stock.
    always_comb begin
        coin_sel_d = 3'b000;
        if (($signed(rem_q) >= 16'sd4) && (stock_1_q != STK_ZERO)) begin
            coin_sel_d = 3'b100;
        end else if (($signed(rem_q) >= 16'sd2) && (stock_05_q != STK_ZERO)) begin
            coin_sel_d = 3'b010;
        end else if (($signed(rem_q) >= 16'sd1) && (stock_025_q != STK_ZERO)) begin
            coin_sel_d = 3'b001;
        end else begin
            coin_sel_d = 3'b000;
        end
    end

    // Payout state machine; every output is a flop updated here.
    always_ff @(posedge in_clka) begin
        if (in_restart) begin
            state_q      <= S_IDLE;
            req_q        <= 3'b000;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            short_q      <= 1'b0;
            short_pend_q <= 1'b0;
            rem_q        <= 16'd0;
            paid_1_q     <= 8'd0;
            stock_1_q    <= STK_INIT;
            stock_05_q   <= STK_INIT;
            stock_025_q  <= STK_INIT;
            tmo_q        <= TMO_ZERO;
        end else begin
            done_q  <= 1'b0;
            short_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (in_start) begin
                        rem_q    <= in_amount;
                        paid_1_q <= 8'd0;
                        busy_q   <= 1'b1;
                        if ($signed(in_amount) > 16'sd0) begin
                            state_q <= S_SELECT;
                        end else begin
                            // zero owes nothing; negative can never be paid
                            short_pend_q <= in_amount[15];
                            state_q      <= S_FINISH;
                        end
                    end else if (in_refill) begin
                        stock_1_q   <= STK_INIT;
                        stock_05_q  <= STK_INIT;
                        stock_025_q <= STK_INIT;
                    end
                end
                S_SELECT: begin
                    tmo_q <= TMO_ZERO;
                    if (rem_q == 16'd0) begin
                        short_pend_q <= 1'b0;
                        state_q      <= S_FINISH;
                    end else if (coin_sel_d != 3'b000) begin
                        req_q   <= coin_sel_d;
                        state_q <= S_WAIT;
                    end else begin
                        short_pend_q <= 1'b1;
                        state_q      <= S_FINISH;
                    end
                end
                S_WAIT: begin
                    if (in_hopper_ack) begin
                        req_q   <= 3'b000;
                        rem_q   <= rem_q - coin_value(req_q);
                        state_q <= S_SELECT;
                        case (req_q)
                            3'b100: begin
                                stock_1_q <= stock_1_q - STK_ONE;
                                paid_1_q  <= sat_inc8(paid_1_q);
                            end
                            3'b010:  stock_05_q  <= stock_05_q - STK_ONE;
                            3'b001:  stock_025_q <= stock_025_q - STK_ONE;
                            default: stock_1_q   <= stock_1_q;
                        endcase
                    end else if (tmo_q == TMO_LAST) begin
                        // hopper stalled: give up, this coin is not counted
                        req_q        <= 3'b000;
                        short_pend_q <= 1'b1;
                        state_q      <= S_FINISH;
                    end else begin
                        tmo_q <= tmo_q + TMO_ONE;
                    end
                end
                S_FINISH: begin
                    done_q  <= 1'b1;
                    short_q <= short_pend_q;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    req_q   <= 3'b000;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign out_coin_1    = req_q[2];
    assign out_coin_05   = req_q[1];
    assign out_coin_025  = req_q[0];
    assign out_busy      = busy_q;
    assign out_done      = done_q;
    assign out_short     = short_q;
    assign out_remaining = rem_q;
    assign out_paid_1    = paid_1_q;
    assign out_stock_1   = stock_1_q;
    assign out_stock_05  = stock_05_q;
    assign out_stock_025 = stock_025_q;

endmodule

// File: tb/tb_change_payout_ctrl.sv
// Bench for change_payout_ctrl: transaction-level greedy payout model plus a
// per-cycle compare process, and a few literal checks on directed scenarios.
module tb_change_payout_ctrl;

    localparam int INIT = 10;
    localparam int TMO  = 15;

    logic        clk = 1'b0;
    logic        in_restart, in_start, in_refill, in_hopper_ack;
    logic [15:0] in_amount;
    logic        out_coin_1, out_coin_05, out_coin_025;
    logic        out_busy, out_done, out_short;
    logic [15:0] out_remaining;
    logic [7:0]  out_paid_1;
    logic [7:0]  out_stock_1, out_stock_05, out_stock_025;

    always #5 clk = ~clk;

    change_payout_ctrl #(.CNT_W(8), .INIT_STOCK(INIT), .TIMEOUT(TMO)) dut (
        .in_clka(clk), .in_restart(in_restart), .in_start(in_start),
        .in_amount(in_amount), .in_refill(in_refill), .in_hopper_ack(in_hopper_ack),
        .out_coin_1(out_coin_1), .out_coin_05(out_coin_05), .out_coin_025(out_coin_025),
        .out_busy(out_busy), .out_done(out_done), .out_short(out_short),
        .out_remaining(out_remaining), .out_paid_1(out_paid_1),
        .out_stock_1(out_stock_1), .out_stock_05(out_stock_05), .out_stock_025(out_stock_025)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // expected outputs after the most recent edge
    logic [2:0] e_req;
    logic       e_busy, e_done, e_short;
    int         m_rem;
    logic [7:0] e_paid;
    int         m_stock [3];    // 0:$1 1:$0.50 2:$0.25
    bit         chk_en = 1'b0;

    // observation helpers for the directed checks
    logic [2:0] coins [$];
    logic [2:0] prev_req = 3'b000;
    int         c1_cnt = 0;
    logic       last_short = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("req",   {29'd0, out_coin_1, out_coin_05, out_coin_025}, {29'd0, e_req});
            chk("busy",  {31'd0, out_busy},  {31'd0, e_busy});
            chk("done",  {31'd0, out_done},  {31'd0, e_done});
            chk("short", {31'd0, out_short}, {31'd0, e_short});
            chk("remaining", {16'd0, out_remaining}, {16'd0, m_rem[15:0]});
            chk("paid_1",    {24'd0, out_paid_1},    {24'd0, e_paid});
            chk("stock_1",   {24'd0, out_stock_1},   m_stock[0]);
            chk("stock_05",  {24'd0, out_stock_05},  m_stock[1]);
            chk("stock_025", {24'd0, out_stock_025}, m_stock[2]);
        end
    end

    always @(negedge clk) begin
        logic [2:0] cur;
        cur = {out_coin_1, out_coin_05, out_coin_025};
        if (cur != 3'b000 && prev_req == 3'b000) coins.push_back(cur);
        if (out_coin_1 === 1'b1) c1_cnt++;
        if (out_done === 1'b1) last_short = out_short;
        prev_req = cur;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        in_start = 1'b0; in_refill = 1'b0; in_hopper_ack = 1'b0; in_restart = 1'b0;
        e_done = 1'b0; e_short = 1'b0;
    endtask

    // inputs that must be ignored while a payout is in progress
    task automatic noise();
        in_start  = ($urandom_range(0, 3) == 0);
        in_amount = 16'($urandom);
        in_refill = ($urandom_range(0, 3) == 0);
    endtask

    task automatic do_reset();
        noise();
        in_restart = 1'b1;
        tick();
        e_req = 3'b000; e_busy = 1'b0; m_rem = 0; e_paid = 8'd0;
        for (int i = 0; i < 3; i++) m_stock[i] = INIT;
    endtask

    task automatic fin(input bit sh);
        noise();
        in_hopper_ack = 1'($urandom_range(0, 1));
        tick();
        e_busy = 1'b0; e_done = 1'b1; e_short = sh;
    endtask

    task automatic idle(input int n, input bit rf);
        for (int i = 0; i < n; i++) begin
            bit r;
            r = rf && ($urandom_range(0, 7) == 0);
            in_refill = r;
            in_hopper_ack = 1'($urandom_range(0, 1));
            tick();
            if (r) for (int j = 0; j < 3; j++) m_stock[j] = INIT;
        end
    endtask

    task automatic payout(input int amt, input bit no_ack);
        int v, idx, d;
        in_start = 1'b1; in_amount = amt[15:0];
        in_refill = 1'($urandom_range(0, 1));
        in_hopper_ack = 1'($urandom_range(0, 1));
        tick();
        e_busy = 1'b1; m_rem = amt; e_paid = 8'd0;
        if (amt <= 0) begin
            fin(amt < 0);
            return;
        end
        for (int it = 0; it < 200; it++) begin
            noise();
            in_hopper_ack = 1'($urandom_range(0, 1));
            tick();
            idx = -1; v = 0;
            if (m_rem >= 4 && m_stock[0] > 0) begin idx = 0; v = 4; end
            else if (m_rem >= 2 && m_stock[1] > 0) begin idx = 1; v = 2; end
            else if (m_rem >= 1 && m_stock[2] > 0) begin idx = 2; v = 1; end
            if (idx < 0) begin
                fin(m_rem != 0);
                return;
            end
            e_req = 3'b100 >> idx;
            if (no_ack) begin
                for (int k = 1; k < TMO; k++) begin noise(); tick(); end
                noise(); tick();
                e_req = 3'b000;
                fin(1'b1);
                return;
            end
            d = $urandom_range(0, 3);
            for (int k = 0; k < d; k++) begin noise(); tick(); end
            noise(); in_hopper_ack = 1'b1;
            tick();
            e_req = 3'b000;
            m_rem = m_rem - v;
            m_stock[idx] = m_stock[idx] - 1;
            if (idx == 0 && e_paid != 8'hFF) e_paid = e_paid + 8'd1;
        end
        chk("payout_bound", 32'd1, 32'd0);
    endtask

    initial begin
        in_restart = 1'b0; in_start = 1'b0; in_refill = 1'b0;
        in_hopper_ack = 1'b0; in_amount = 16'd0;
        do_reset();
        chk_en = 1'b1;
        idle(2, 1'b0);

        // 7 quarters with full stock: $1, $0.50, $0.25
        coins.delete();
        payout(7, 1'b0);
        idle(2, 1'b0);
        chk("t1_ncoins", coins.size(), 32'd3);
        chk("t1_coin0", {29'd0, (coins.size() > 0) ? coins[0] : 3'b000}, 32'd4);
        chk("t1_coin1", {29'd0, (coins.size() > 1) ? coins[1] : 3'b000}, 32'd2);
        chk("t1_coin2", {29'd0, (coins.size() > 2) ? coins[2] : 3'b000}, 32'd1);
        chk("t1_rem", {16'd0, out_remaining}, 32'd0);
        chk("t1_stock", {8'd0, out_stock_1, out_stock_05, out_stock_025}, 32'h00090909);
        chk("t1_paid", {24'd0, out_paid_1}, 32'd1);
        chk("t1_short", {31'd0, last_short}, 32'd0);

        // stalled hopper: request held TIMEOUT cycles then abort short
        do_reset();
        c1_cnt = 0;
        payout(4, 1'b1);
        idle(2, 1'b0);
        chk("t4_c1_cycles", c1_cnt, 32'd15);
        chk("t4_rem", {16'd0, out_remaining}, 32'd4);
        chk("t4_stock_1", {24'd0, out_stock_1}, 32'd10);
        chk("t4_short", {31'd0, last_short}, 32'd1);

        // negative amount: never a request, short
        do_reset();
        coins.delete();
        payout(-3, 1'b0);
        idle(2, 1'b0);
        chk("t5_ncoins", coins.size(), 32'd0);
        chk("t5_rem", {16'd0, out_remaining}, 32'h0000FFFD);
        chk("t5_short", {31'd0, last_short}, 32'd1);

        // reset while waiting for the hopper
        do_reset();
        in_start = 1'b1; in_amount = 16'd8;
        tick();
        e_busy = 1'b1; m_rem = 8; e_paid = 8'd0;
        tick();
        e_req = 3'b100;
        tick();
        do_reset();
        chk("t6_busy", {31'd0, out_busy}, 32'd0);
        chk("t6_req", {29'd0, out_coin_1, out_coin_05, out_coin_025}, 32'd0);
        idle(3, 1'b0);

        // $1 stock down to 2, then fallback to $0.50, then shortfall
        do_reset();
        payout(32, 1'b0);
        idle(1, 1'b0);
        coins.delete();
        payout(12, 1'b0);
        idle(1, 1'b0);
        chk("t2_ncoins", coins.size(), 32'd4);
        chk("t2_coin2", {29'd0, (coins.size() > 2) ? coins[2] : 3'b000}, 32'd2);
        chk("t2_stock", {8'd0, out_stock_1, out_stock_05, out_stock_025}, 32'h0000080A);
        chk("t2_short", {31'd0, last_short}, 32'd0);
        payout(40, 1'b0);
        idle(1, 1'b0);
        chk("t3_rem", {16'd0, out_remaining}, 32'd14);
        chk("t3_stock", {8'd0, out_stock_1, out_stock_05, out_stock_025}, 32'd0);
        chk("t3_short", {31'd0, last_short}, 32'd1);

        // randomized payouts against the model
        do_reset();
        for (int n = 0; n < 150; n++) begin
            int amt;
            if ($urandom_range(0, 9) == 0) amt = -int'($urandom_range(1, 5));
            else amt = int'($urandom_range(0, 40));
            payout(amt, ($urandom_range(0, 9) == 0));
            idle(int'($urandom_range(0, 3)), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
